// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution sequencer: FSM encoding,
// datapath widths and job geometry.
package conv_pkg;

  localparam int DATA_W     = 32;
  localparam int FEAT_W     = 64;
  localparam int WGT_W      = 72;
  localparam int RES_W      = 32;
  localparam int ADDR_W     = 3;
  localparam int ROWS       = 8;
  localparam int RUN_CYCLES = 16;
  localparam int W_WORDS    = 3;

  localparam int WCNT_W = 3;
  localparam int FCNT_W = 4;
  localparam int RCNT_W = 8;

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(2 * W_WORDS - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(2 * ROWS - 1);
  localparam logic [RCNT_W-1:0] RUN_LOAD  = RCNT_W'(RUN_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_F = 3'd2,
    RUN    = 3'd3,
    HOLD   = 3'd4
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/conv_word_packer.sv
// Packs accepted 32-bit stream words into the two 72-bit weight vectors and
// the 64-bit feature row, and issues the one-cycle row write strobe.
module conv_word_packer
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wgt_acc,
  input  logic [WCNT_W-1:0] i_wgt_idx,
  input  logic              i_feat_acc,
  input  logic              i_feat_odd,
  input  logic [ADDR_W-1:0] i_row,
  input  logic [DATA_W-1:0] i_data,
  output logic [WGT_W-1:0]  o_wi0,
  output logic [WGT_W-1:0]  o_wi1,
  output logic [FEAT_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_we
);

  // NOTE: the weight vectors are plain registers, not a RAM, so they take
  // the async reset like everything else and read as zero after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wi0  <= '0;
      o_wi1  <= '0;
      o_data <= '0;
      o_addr <= '0;
      o_we   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      o_we <= i_feat_acc && i_feat_odd;
      if (i_wgt_acc) begin
        case (i_wgt_idx)
          3'd0:    o_wi0[31:0]  <= i_data;
          3'd1:    o_wi0[63:32] <= i_data;
          3'd2:    o_wi0[71:64] <= i_data[31:24];
          3'd3:    o_wi1[31:0]  <= i_data;
          3'd4:    o_wi1[63:32] <= i_data;
          3'd5:    o_wi1[71:64] <= i_data[31:24];
          default: ;
        endcase
      end
      if (i_feat_acc) begin
        if (!i_feat_odd) begin
          o_data[31:0] <= i_data;
        end else begin
          o_data[63:32] <= i_data;
          o_addr        <= i_row;
        end
      end
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Job sequencer for the two-engine convolution datapath: weight/feature
// streaming, timed engine run and result handshake. Define CONV_SEQ_PERF_EN
// to add the perf_cycles job-latency counter.
module conv_seq_ctrl
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              skip_w,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              eng_en,
  output logic              eng_we,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [FEAT_W-1:0] eng_data,
  output logic [WGT_W-1:0]  eng_wi0,
  output logic [WGT_W-1:0]  eng_wi1,
  input  logic [15:0]       eng_outa,
  input  logic [15:0]       eng_outb,
  output logic              res_valid,
  output logic [RES_W-1:0]  res_data,
  input  logic              res_ack,
  output logic              busy,
  output logic              err
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  state_e            r_state, w_next;
  logic [WCNT_W-1:0] r_wcnt;
  logic [FCNT_W-1:0] r_fcnt;
  logic [RCNT_W-1:0] r_run_cnt;
  logic              r_res_valid;
  logic [RES_W-1:0]  r_res_data;
  logic              r_err;

  logic w_acc, w_wgt_acc, w_feat_acc, w_wgt_last, w_feat_last, w_capture;

  assign s_ready = (r_state == LOAD_W) || (r_state == LOAD_F);
  assign eng_en  = (r_state == RUN);
  assign busy    = (r_state != IDLE);

  // A word offered in the abort cycle is never consumed.
  assign w_acc       = s_valid && s_ready && !abort;
  assign w_wgt_acc   = w_acc && (r_state == LOAD_W);
  assign w_feat_acc  = w_acc && (r_state == LOAD_F);
  assign w_wgt_last  = (r_wcnt == WCNT_LAST);
  assign w_feat_last = (r_fcnt == FCNT_LAST);
  assign w_capture   = (r_state == HOLD) && !r_res_valid && !abort;

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next = skip_w ? LOAD_F : LOAD_W;
        LOAD_W:  if (w_wgt_acc && w_wgt_last) w_next = LOAD_F;
        LOAD_F:  if (w_feat_acc && w_feat_last) w_next = RUN;
        RUN:     if (r_run_cnt == RCNT_W'(1)) w_next = HOLD;
        HOLD:    if (r_res_valid && res_ack) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt      <= '0;
      r_fcnt      <= '0;
      r_run_cnt   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= start && (r_state != IDLE);
      if (abort) begin
        r_wcnt      <= '0;
        r_fcnt      <= '0;
        r_run_cnt   <= '0;
        r_res_valid <= 1'b0;
      end else begin
        if (w_wgt_acc)  r_wcnt <= w_wgt_last  ? '0 : r_wcnt + 1'b1;
        if (w_feat_acc) r_fcnt <= w_feat_last ? '0 : r_fcnt + 1'b1;
        if (w_feat_acc && w_feat_last) r_run_cnt <= RUN_LOAD;
        else if (r_state == RUN)       r_run_cnt <= r_run_cnt - 1'b1;
        if (w_capture) begin
          r_res_data  <= {eng_outb, eng_outa};
          r_res_valid <= 1'b1;
        end else if ((r_state == HOLD) && r_res_valid && res_ack) begin
          r_res_valid <= 1'b0;
        end
      end
    end
  end

  conv_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wgt_acc  (w_wgt_acc),
    .i_wgt_idx  (r_wcnt),
    .i_feat_acc (w_feat_acc),
    .i_feat_odd (r_fcnt[0]),
    .i_row      (r_fcnt[FCNT_W-1:1]),
    .i_data     (s_data),
    .o_wi0      (eng_wi0),
    .o_wi1      (eng_wi1),
    .o_data     (eng_data),
    .o_addr     (eng_addr),
    .o_we       (eng_we)
  );

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] r_perf_cnt;

  // Counts edges since the start edge; the capture edge itself is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cnt  <= '0;
      perf_cycles <= '0;
    end else if (abort) begin
      r_perf_cnt <= '0;
    end else begin
      if ((r_state == IDLE) && start) r_perf_cnt <= '0;
      else if (busy)                  r_perf_cnt <= sat_inc(r_perf_cnt);
      if (w_capture) perf_cycles <= sat_inc(r_perf_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: scoreboarded row writes, weight packing,
// run length, result handshake, skip_w, backpressure, abort and reset.
module tb_conv_seq_ctrl;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, skip_w = 1'b0, abort = 1'b0;
  logic        s_valid = 1'b0, res_ack = 1'b0;
  logic [31:0] s_data = '0;
  logic [15:0] eng_outa = '0, eng_outb = '0;
  logic        s_ready, eng_en, eng_we, res_valid, busy, err;
  logic [2:0]  eng_addr;
  logic [63:0] eng_data;
  logic [71:0] eng_wi0, eng_wi1;
  logic [31:0] res_data;

  typedef struct packed {
    logic [2:0]  addr;
    logic [63:0] data;
  } row_t;

  row_t        exp_q[$];
  row_t        obs_q[$];
  row_t        mon_row;
  int          obs_rd = 0;
  int          en_total = 0;
  int          n_cmp = 0, n_err = 0;
  logic [71:0] exp_wi0 = '0, exp_wi1 = '0;

  conv_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .skip_w(skip_w), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .eng_en(eng_en), .eng_we(eng_we), .eng_addr(eng_addr), .eng_data(eng_data),
    .eng_wi0(eng_wi0), .eng_wi1(eng_wi1), .eng_outa(eng_outa), .eng_outb(eng_outb),
    .res_valid(res_valid), .res_data(res_data), .res_ack(res_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Observer: records every row write and counts enabled engine cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_en) en_total++;
      if (eng_we) begin
        mon_row.addr = eng_addr;
        mon_row.data = eng_data;
        obs_q.push_back(mon_row);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] d);
    int w = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && w < 50) begin
      tick();
      w++;
    end
    check("s_ready_for_word", 72'(s_ready), 72'd1);
    tick();
  endtask

  task automatic do_start(input logic skip);
    start  = 1'b1;
    skip_w = skip;
    tick();
    start  = 1'b0;
    skip_w = 1'b0;
  endtask

  task automatic load_weights(input logic [31:0] w [6]);
    for (int i = 0; i < 6; i++) begin
      send_word(w[i]);
      if (i == 0) check("wi0_after_word0", eng_wi0, {exp_wi0[71:32], w[0]});
    end
    s_valid = 1'b0;
    exp_wi0 = {w[2][31:24], w[1], w[0]};
    exp_wi1 = {w[5][31:24], w[4], w[3]};
    check("wi0_loaded", eng_wi0, exp_wi0);
    check("wi1_loaded", eng_wi1, exp_wi1);
  endtask

  // Streams n_words feature words; expected rows enter the scoreboard as driven.
  task automatic send_rows(input logic [31:0] seed, input bit bp, input int n_words);
    logic [31:0] lo, hi;
    row_t e;
    for (int i = 0; i < n_words; i++) begin
      lo = seed + 32'(i / 2) * 32'h0101_0101;
      hi = {lo[15:0], lo[31:16]} ^ 32'hFFFF_0000;
      if (i % 2 == 0) begin
        send_word(lo);
        if (i == 0) begin
          check("first_word_low_half", 72'(eng_data[31:0]), 72'(lo));
          check("wi0_unchanged", eng_wi0, exp_wi0);
          check("wi1_unchanged", eng_wi1, exp_wi1);
        end
      end else begin
        e.addr = 3'(i / 2);
        e.data = {hi, lo};
        exp_q.push_back(e);
        send_word(hi);
      end
      if (bp) begin
        s_valid = 1'b0;
        tick();
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic compare_rows(input string tag);
    row_t e, o;
    tick();
    check($sformatf("%s_row_count", tag), 72'(obs_q.size() - obs_rd), 72'(exp_q.size()));
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      check($sformatf("%s_row_addr", tag), 72'(o.addr), 72'(e.addr));
      check($sformatf("%s_row_data", tag), 72'(o.data), 72'(e.data));
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic wait_result(input string tag);
    int w = 0;
    while (!res_valid && w < 200) begin
      tick();
      w++;
    end
    check($sformatf("%s_res_valid", tag), 72'(res_valid), 72'd1);
  endtask

  task automatic finish_job(input string tag);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check($sformatf("%s_res_valid_clear", tag), 72'(res_valid), 72'd0);
    check($sformatf("%s_idle", tag), 72'(busy), 72'd0);
  endtask

  initial begin
    logic [31:0] wa [6];
    logic [31:0] wb [6];
    int en0;

    wa = '{32'h1111_1111, 32'h2222_2222, 32'h3300_0000,
           32'hAA00_0000, 32'hAA00_0000, 32'hAA00_0000};
    wb = '{32'h4444_4444, 32'h5555_5555, 32'h6600_0000,
           32'h7777_7777, 32'h8888_8888, 32'h9900_0000};

    repeat (3) tick();
    check("reset_busy", 72'(busy), 72'd0);
    check("reset_s_ready", 72'(s_ready), 72'd0);
    check("reset_res_valid", 72'(res_valid), 72'd0);
    check("reset_wi0", eng_wi0, 72'd0);
    rst_n = 1'b1;
    tick();

    // Full job with weight load.
    eng_outa = 16'd7;
    eng_outb = 16'd5;
    do_start(1'b0);
    check("load_w_ready", 72'(s_ready), 72'd1);
    load_weights(wa);
    check("wi0_value", eng_wi0, 72'h33_22222222_11111111);
    en0 = en_total;
    send_rows(32'h1000_0001, 1'b0, 16);
    wait_result("job1");
    check("job1_en_cycles", 72'(en_total - en0), 72'd16);
    check("job1_res_data", 72'(res_data), 72'h0005_0007);
    compare_rows("job1");

    // Result held without ack; start in HOLD flags err once.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_res_valid", 72'(res_valid), 72'd1);
      check("hold_res_data", 72'(res_data), 72'h0005_0007);
      check("hold_busy", 72'(busy), 72'd1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hold_err_pulse", 72'(err), 72'd1);
    tick();
    check("hold_err_single", 72'(err), 72'd0);
    check("hold_still_valid", 72'(res_valid), 72'd1);
    finish_job("job1");
    tick();
    check("no_queued_start", 72'(busy), 72'd0);

    // Stream ignored in IDLE, then skip_w job.
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    tick();
    check("idle_not_ready", 72'(s_ready), 72'd0);
    s_valid = 1'b0;
    eng_outa = 16'h1234;
    eng_outb = 16'hBEEF;
    do_start(1'b1);
    en0 = en_total;
    send_rows(32'h2000_0002, 1'b0, 16);
    wait_result("skip");
    check("skip_en_cycles", 72'(en_total - en0), 72'd16);
    check("skip_res_data", 72'(res_data), 72'hBEEF_1234);
    compare_rows("skip");
    finish_job("skip");

    // Backpressure on the feature stream.
    do_start(1'b1);
    send_rows(32'h3000_0003, 1'b1, 16);
    wait_result("bp");
    compare_rows("bp");
    finish_job("bp");

    // Abort in the middle of row 3: the offered word is dropped.
    do_start(1'b1);
    send_rows(32'h4000_0004, 1'b0, 7);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hCAFE_F00D;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    check("abort_idle", 72'(busy), 72'd0);
    check("abort_s_ready", 72'(s_ready), 72'd0);
    check("abort_we", 72'(eng_we), 72'd0);
    check("abort_wi0_kept", eng_wi0, exp_wi0);
    check("abort_wi1_kept", eng_wi1, exp_wi1);
    compare_rows("abort");
    do_start(1'b1);
    send_rows(32'h5000_0005, 1'b0, 16);
    wait_result("post_abort");
    compare_rows("post_abort");
    finish_job("post_abort");

    // Asynchronous reset in the middle of RUN.
    do_start(1'b1);
    send_rows(32'h6000_0006, 1'b0, 16);
    repeat (5) tick();
    check("run_en", 72'(eng_en), 72'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_en", 72'(eng_en), 72'd0);
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_s_ready", 72'(s_ready), 72'd0);
    check("rst_we", 72'(eng_we), 72'd0);
    check("rst_res_valid", 72'(res_valid), 72'd0);
    check("rst_res_data", 72'(res_data), 72'd0);
    check("rst_err", 72'(err), 72'd0);
    check("rst_addr", 72'(eng_addr), 72'd0);
    check("rst_data", 72'(eng_data), 72'd0);
    check("rst_wi0", eng_wi0, 72'd0);
    check("rst_wi1", eng_wi1, 72'd0);
    compare_rows("pre_reset");
    exp_wi0 = '0;
    exp_wi1 = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Normal job after reset.
    eng_outa = 16'h0F0F;
    eng_outb = 16'hA5A5;
    do_start(1'b0);
    load_weights(wb);
    check("wi0_after_reset", eng_wi0, 72'h66_55555555_44444444);
    check("wi1_after_reset", eng_wi1, 72'h99_88888888_77777777);
    en0 = en_total;
    send_rows(32'h7000_0007, 1'b0, 16);
    wait_result("final");
    check("final_en_cycles", 72'(en_total - en0), 72'd16);
    check("final_res_data", 72'(res_data), 72'hA5A5_0F0F);
    compare_rows("final");
    finish_job("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
